exec_stage_mc: RTL

Parametrised execute stage for the pipelined CPU. It extends the single-cycle 8-bit execute path with a configurable datapath width and a carry/zero flag pair that is registered with separate write enables. It adds a registered EX/MEM output with a valid/ready handshake and a multi-cycle unsigned multiplier that stalls issue while it runs. It sits between the ID/EX pipeline register and the EX/MEM register and keeps the two-source forwarding network in front of the ALU.

---
 rtl/exec_stage_mc.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, shift-add multiplier and
// registered carry/zero flags feeding a registered EX/MEM result with a valid pulse.
module exec_stage_mc #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   ra,
  input  logic [WIDTH-1:0]   rb,
  input  logic [WIDTH-1:0]   imm,
  input  logic               b_imm_sel,
  input  logic [1:0]         a_fwd_sel,
  input  logic [1:0]         b_fwd_sel,
  input  logic [WIDTH-1:0]   ex_mem_fwd,
  input  logic [WIDTH-1:0]   mem_wb_fwd,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               c_en,
  input  logic               z_en,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_result,
  output logic               c_flag,
  output logic               z_flag,
  output logic               dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_PSB = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  // Handshake: an operation is taken on a rising edge when in_valid and in_ready
  // are both high and flush is low; out_valid is a one-cycle pulse per result.
  state_t               state_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_result_q;
  logic                 c_q, z_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 mul_c_en_q, mul_z_en_q;

  logic [WIDTH-1:0]     opa_d, opb_base_d, opb_d;
  logic [WIDTH:0]       sum_d, diff_d;
  logic [SHAMT_W-1:0]   rot_amt_d;
  logic [WIDTH-1:0]     rol_d, ror_d;
  logic                 shl_c_d, shr_c_d, shamt_zero_d;
  logic [WIDTH-1:0]     alu_res_d;
  logic                 alu_c_d, c_def_d, z_def_d;
  logic                 accept_d;
  logic [2*WIDTH-1:0]   acc_step_d;
  logic                 mul_last_d;

  assign in_ready   = (state_q == ST_IDLE);
  assign accept_d   = in_valid & in_ready & ~flush;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign c_flag     = c_q;
  assign z_flag     = z_q;
  assign dbg_state  = (state_q == ST_MUL);

  always_comb begin
    opb_base_d = b_imm_sel ? imm : rb;
    case (a_fwd_sel)
      2'd1:    opa_d = ex_mem_fwd;
      2'd2:    opa_d = mem_wb_fwd;
      default: opa_d = ra;
    endcase
    case (b_fwd_sel)
      2'd1:    opb_d = ex_mem_fwd;
      2'd2:    opb_d = mem_wb_fwd;
      default: opb_d = opb_base_d;
    endcase
  end

  // The extra top bit of sum/diff is the carry or the borrow.
  always_comb begin
    sum_d  = {1'b0, opa_d} + {1'b0, opb_d} + {{WIDTH{1'b0}}, (op == OP_ADC) & c_q};
    diff_d = {1'b0, opa_d} - {1'b0, opb_d} - {{WIDTH{1'b0}}, (op == OP_SBC) & c_q};
    rot_amt_d    = SHAMT_W'(int'(shamt) % WIDTH);
    rol_d        = (opa_d << rot_amt_d) | (opa_d >> (WIDTH - int'(rot_amt_d)));
    ror_d        = (opa_d >> rot_amt_d) | (opa_d << (WIDTH - int'(rot_amt_d)));
    shamt_zero_d = (shamt == '0);
    shl_c_d = 1'b0;
    shr_c_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(shamt) == WIDTH - i) shl_c_d = opa_d[i];
      if (int'(shamt) == i + 1)     shr_c_d = opa_d[i];
    end
  end

  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    c_def_d   = 1'b0;
    z_def_d   = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin alu_res_d = sum_d[WIDTH-1:0];  alu_c_d = sum_d[WIDTH];  c_def_d = 1'b1; end
      OP_SUB, OP_SBC: begin alu_res_d = diff_d[WIDTH-1:0]; alu_c_d = diff_d[WIDTH]; c_def_d = 1'b1; end
      OP_AND: alu_res_d = opa_d & opb_d;
      OP_OR:  alu_res_d = opa_d | opb_d;
      OP_XOR: alu_res_d = opa_d ^ opb_d;
      OP_PSB: alu_res_d = opb_d;
      OP_SHL: begin alu_res_d = opa_d << shamt; alu_c_d = shl_c_d;  c_def_d = ~shamt_zero_d; end
      OP_SHR: begin alu_res_d = opa_d >> shamt; alu_c_d = shr_c_d;  c_def_d = ~shamt_zero_d; end
      // Last bit rotated out lands at the far end of the result.
      OP_ROL: begin alu_res_d = rol_d; alu_c_d = rol_d[0];       c_def_d = ~shamt_zero_d; end
      OP_ROR: begin alu_res_d = ror_d; alu_c_d = ror_d[WIDTH-1]; c_def_d = ~shamt_zero_d; end
      OP_MUL: c_def_d = 1'b1;
      default: z_def_d = 1'b0;
    endcase
  end

  assign acc_step_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last_d = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      mul_c_en_q   <= 1'b0;
      mul_z_en_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            if (op == OP_MUL) begin
              mcand_q    <= {{WIDTH{1'b0}}, opa_d};
              mplier_q   <= opb_d;
              acc_q      <= '0;
              cnt_q      <= '0;
              mul_c_en_q <= c_en;
              mul_z_en_q <= z_en;
              state_q    <= ST_MUL;
            end else begin
              out_valid_q  <= 1'b1;
              out_result_q <= alu_res_d;
              if (c_en && c_def_d) c_q <= alu_c_d;
              if (z_en && z_def_d) z_q <= (alu_res_d == '0);
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q    <= acc_step_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (mul_last_d) begin
              out_valid_q  <= 1'b1;
              out_result_q <= acc_step_d[WIDTH-1:0];
              if (mul_c_en_q) c_q <= |acc_step_d[2*WIDTH-1:WIDTH];
              if (mul_z_en_q) z_q <= (acc_step_d[WIDTH-1:0] == '0);
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
